// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte FIFO between the UART receiver and the bus.
// Captures bytes on rx_end, returns them on rd_en with one clock of latency,
// and reports fill level, a sticky overflow flag and a threshold interrupt.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int THRESH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_end,
    input  logic [7:0]        rx_data,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              flush,
    input  logic              ovf_clr,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              irq
);

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   THRESH_C = (ADDR_W + 1)'(THRESH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO = ADDR_W'(0);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              irq_q, irq_d;

    logic              pop_ok_s;
    logic              push_ok_s;
    logic              ovf_evt_s;
    logic              mem_we_s;

    // Accept/reject decisions for this cycle, all based on the pre-edge count.
    always_comb begin
        pop_ok_s  = rd_en && (count_q != CNT_ZERO);
        // A push into a full FIFO is still accepted when a pop frees a slot.
        push_ok_s = rx_end && ((count_q != DEPTH_C) || pop_ok_s);
        ovf_evt_s = rx_end && !push_ok_s;
        mem_we_s  = push_ok_s && !flush && !reset;
    end

    // Next-state computation; flush overrides any push/pop in the same cycle.
    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        overflow_d = overflow_q;
        if (flush) begin
            wp_d    = PTR_ZERO;
            rp_d    = PTR_ZERO;
            count_d = CNT_ZERO;
            // Flush never sets overflow, but a concurrent clear still applies.
            if (ovf_clr) begin
                overflow_d = 1'b0;
            end else begin
                overflow_d = overflow_q;
            end
        end else begin
            if (push_ok_s) begin
                wp_d = wp_q + PTR_ONE;
            end else begin
                wp_d = wp_q;
            end
            if (pop_ok_s) begin
                rp_d       = rp_q + PTR_ONE;
                rd_data_d  = mem_q[rp_q];
                rd_valid_d = 1'b1;
            end else begin
                rp_d       = rp_q;
                rd_data_d  = rd_data_q;
                rd_valid_d = 1'b0;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            // A new overflow wins over a simultaneous clear.
            if (ovf_evt_s) begin
                overflow_d = 1'b1;
            end else if (ovf_clr) begin
                overflow_d = 1'b0;
            end else begin
                overflow_d = overflow_q;
            end
        end
        irq_d = (count_d >= THRESH_C);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q       <= PTR_ZERO;
            rp_q       <= PTR_ZERO;
            count_q    <= CNT_ZERO;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
        end
    end

    // Byte storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wp_q] <= rx_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign irq      = irq_q;
    assign empty    = (count_q == CNT_ZERO);
    assign full     = (count_q == DEPTH_C);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: the stimulus process queues the byte each
// accepted read must return; a negedge monitor checks rd_valid timing and data.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_end = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       flush = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       irq;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic       exp_vld = 1'b0;
    logic       mon_en = 1'b0;

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4), .THRESH(8)) dut (
        .clk(clk), .reset(reset), .rx_end(rx_end), .rx_data(rx_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .flush(flush), .ovf_clr(ovf_clr), .empty(empty), .full(full),
        .count(count), .overflow(overflow), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // Monitor: rd_valid must match the expected pulse; data comes from the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            n_vec++;
            if (rd_valid !== exp_vld) begin
                n_err++;
                $display("FAIL rd_valid_timing: got %b want %b at %0t", rd_valid, exp_vld, $time);
            end
            if (rd_valid === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_data_spurious: got %h with empty scoreboard", rd_data);
                end else begin
                    automatic logic [7:0] e = exp_q.pop_front();
                    if (rd_data !== e) begin
                        n_err++;
                        $display("FAIL rd_data: got %h want %h at %0t", rd_data, e, $time);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // One clock of stimulus; exp_pop says whether this read should be accepted.
    task automatic cyc(input logic rst, input logic rx, input logic [7:0] d,
                       input logic rd, input logic exp_pop, input logic [7:0] exp_byte,
                       input logic fl, input logic clr);
        reset = rst; rx_end = rx; rx_data = d; rd_en = rd; flush = fl; ovf_clr = clr;
        if (exp_pop) exp_q.push_back(exp_byte);
        @(posedge clk);
        exp_vld = exp_pop;
        #1;
        reset = 1'b0; rx_end = 1'b0; rd_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        cyc(1'b0, 1'b1, d, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pop(input logic [7:0] e);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, e, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        #1;
        // Reset
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        mon_en = 1'b1;
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_irq", irq, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);

        // Basic push/pop of three bytes
        push(8'h41); push(8'h42); push(8'h43);
        chk("basic_count3", count, 3);
        pop(8'h41); pop(8'h42); pop(8'h43);
        idle();
        chk("basic_count0", count, 0);
        chk("basic_empty", empty, 1);

        // Fill to full, irq threshold, overflow
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            chk("fill_count", count, i + 1);
            chk("fill_irq", irq, (i + 1 >= 8) ? 1 : 0);
        end
        chk("fill_full", full, 1);
        push(8'hFF);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 16);
        for (int i = 0; i < 16; i++) pop(8'(i));
        idle();
        chk("drain_empty", empty, 1);
        chk("drain_ovf_sticky", overflow, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", overflow, 0);

        // Full with simultaneous push and pop, then drain across the wrap
        for (int i = 0; i < 16; i++) push(8'(i));
        cyc(1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("fullpp_count", count, 16);
        chk("fullpp_ovf", overflow, 0);
        for (int i = 1; i < 16; i++) pop(8'(i));
        pop(8'hAA);
        idle();
        chk("wrap_empty", empty, 1);
        chk("wrap_irq", irq, 0);

        // Empty with simultaneous push and pop: only the push counts
        cyc(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("emptypp_count", count, 1);
        pop(8'h55);
        idle();
        chk("emptypp_count0", count, 0);

        // Flush with a concurrent push; overflow preserved (set it first)
        for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
        push(8'hEE);
        chk("pre_flush_ovf", overflow, 1);
        cyc(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_irq", irq, 0);
        chk("flush_ovf", overflow, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        idle();

        // Reset in the same cycle as an accepted-looking read
        push(8'h80); push(8'h81); push(8'h82); push(8'h83);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_count", count, 0);
        chk("midrst_rd_data", rd_data, 8'h00);
        chk("midrst_ovf", overflow, 0);
        chk("midrst_empty", empty, 1);
        idle();
        idle();

        chk("scoreboard_drained", exp_q.size(), 0);
        @(negedge clk);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer placed directly downstream of the UART receiver. It captures each received byte on the receiver's one-cycle completion pulse and holds it in a circular FIFO until the bus-side register logic reads it. It also reports fill level, a sticky overflow flag and a threshold interrupt, so the CPU need not service every byte as it arrives.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
ADDR_W, 4, pointer width; must equal log2(DEPTH)
THRESH, 8, fill level at or above which irq asserts; range 1..DEPTH

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
rx_end  input  1  one-cycle pulse from receiver: rx_data is a valid byte
rx_data  input  8  received byte, sampled only when rx_end=1
rd_en  input  1  bus read request, one-cycle pulse
rd_data  output  8  read data, registered
rd_valid  output  1  one-cycle pulse: rd_data holds the popped byte
flush  input  1  discard all stored bytes
ovf_clr  input  1  clear the sticky overflow flag
empty  output  1  count==0
full  output  1  count==DEPTH
count  output  ADDR_W+1  number of stored bytes, 0..DEPTH
overflow  output  1  sticky: at least one byte was dropped
irq  output  1  count>=THRESH, registered

Behaviour:
- Reset is sampled only on a rising clk edge with reset=1. It clears the pointers and count, and sets rd_data=8'h00, rd_valid=0, overflow=0 and irq=0. Outputs then read empty=1, full=0, count=0. Storage contents are don't-care.
- Storage: DEPTH x 8 array with write pointer wp and read pointer rp, each ADDR_W bits. Pointers wrap modulo DEPTH with natural overflow, no compare-and-reset. count is a separate ADDR_W+1-bit register.
- Events are evaluated each cycle with this priority: reset > flush > push/pop.
- Push request: rx_end=1.
  - Accepted when count<DEPTH, or when count==DEPTH and a pop is accepted in the same cycle.
  - Accepted push writes mem[wp] <= rx_data and increments wp.
- Pop request: rd_en=1.
  - Accepted only when count>0, evaluated on the pre-edge count.
  - Accepted pop sets rd_data <= mem[rp] on the same edge, increments rp, and drives rd_valid=1 in the following cycle.
  - Read latency is 1 clock from rd_en to rd_valid.
- rd_en with count==0 (underflow): ignored. rd_valid stays 0, rd_data holds its previous value, and no flag is raised.
- rd_valid is 1 for exactly one cycle per accepted pop and 0 otherwise. rd_data holds its value until the next accepted pop.
- count update: +1 for push only, -1 for pop only, unchanged for both or neither.
- Simultaneous push and pop:
  - When count==0, only the push is accepted (the pop is an underflow) and count becomes 1.
  - When count==DEPTH, both are accepted and count stays DEPTH. The popped byte is the oldest one, not the new byte.
- Overflow: rx_end=1 while count==DEPTH with no accepted pop.
  - The byte is dropped and the pointers and count are unchanged.
  - overflow <= 1 on that edge.
- overflow stays set until ovf_clr=1 or reset. If ovf_clr and a new overflow occur in the same cycle, overflow stays 1 (set wins).
- flush=1:
  - wp, rp and count go to 0 on that edge; rd_valid=0 next cycle.
  - Any rx_end or rd_en in the same cycle is discarded; the byte is lost and overflow is not set.
  - overflow is unaffected by flush.
- irq <= (next count >= THRESH). It is registered, so it changes on the same edge as count, and it is a level signal, not a pulse.
- empty and full are combinational decodes of the count register.
- Reset mid-operation (stored bytes, pending rd_valid): everything returns to reset values on that edge and no rd_valid pulse follows.

Test Plan:
- Reset, then push 8'h41, 8'h42, 8'h43 on separate rx_end pulses, then issue 3 rd_en pulses -> rd_data 41,42,43 each with a 1-cycle rd_valid one clock after its rd_en; count goes 3->0 and empty=1.
- Push 16 bytes 8'h00..8'h0F -> full=1, count=16, irq=1 from the 8th push onward. A 17th rx_end with 8'hFF gives overflow=1 and count=16; reading all 16 returns 00..0F with no FF. ovf_clr then gives overflow=0.
- Fill to 16, then assert rx_end=8'hAA and rd_en together -> rd_data=8'h00, count stays 16, overflow=0. Draining then yields 01..0F followed by AA, exercising wrap-around.
- With the FIFO empty, assert rd_en and rx_end=8'h55 in the same cycle -> no rd_valid, count=1. The next rd_en returns 55.
- Store 5 bytes, then assert flush together with rx_end=8'h77 -> count=0, empty=1, irq=0, overflow unchanged. A following rd_en produces no rd_valid.
- Store 4 bytes and issue rd_en, asserting reset on the next edge -> rd_valid=0 on that edge, count=0, rd_data=8'h00, overflow=0.
